line_loader: RTL and testbench

LINE_LOADER -- requirements
Module: line_loader

---
 rtl/line_loader.sv | 116 +++++++++++
 tb/tb_line_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/line_loader.sv
// rtl/line_loader.sv - text-mode scanline loader: text RAM -> font ROM -> line buffer, one column per clock.
module line_loader #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int FONT_H = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LINE_START,
    input  logic [9:0]  ROW_NUM,
    output logic [11:0] TXT_ADDR,
    input  logic [7:0]  TXT_DATA,
    output logic [7:0]  FONT_CHAR,
    output logic [3:0]  FONT_ROW,
    input  logic [7:0]  FONT_DATA,
    output logic        LB_WE,
    output logic [6:0]  LB_ADDR,
    output logic [7:0]  LB_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERRUN
);

    localparam logic [10:0] ROW_LIMIT = 11'(ROWS * FONT_H);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] col, col_nxt;
    logic       flush_cnt, flush_nxt;
    logic       load, issue;
    logic [5:0] trow;
    logic [3:0] frow;

    // stage 2 holds the column whose character code is arriving; stage 3 the one whose glyph row is arriving
    logic       s2_valid, s3_valid;
    logic [6:0] s2_col, s3_col;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            col       <= '0;
            flush_cnt <= 1'b0;
            trow      <= '0;
            frow      <= '0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s2_col    <= '0;
            s3_col    <= '0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            flush_cnt <= flush_nxt;
            if (load) begin
                trow <= ROW_NUM[9:4];
                frow <= ROW_NUM[3:0];
            end
            s2_valid <= issue;
            s2_col   <= col;
            s3_valid <= s2_valid;
            s3_col   <= s2_col;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        flush_nxt = flush_cnt;
        load      = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                // rows at or beyond the visible area fall in vertical blank and are ignored
                if (LINE_START && ({1'b0, ROW_NUM} < ROW_LIMIT)) begin
                    load      = 1'b1;
                    col_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (col == LAST_COL) begin
                    col_nxt   = '0;
                    flush_nxt = 1'b0;
                    state_nxt = FLUSH;
                end else begin
                    col_nxt = col + 7'd1;
                end
            end
            FLUSH: begin
                if (flush_cnt) begin
                    state_nxt = IDLE;
                end else begin
                    flush_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY      = (state != IDLE);
    assign OVERRUN   = LINE_START && BUSY;
    assign TXT_ADDR  = issue ? (12'(trow) * 12'(COLS) + 12'(col)) : 12'd0;
    assign FONT_CHAR = s2_valid ? TXT_DATA : 8'd0;
    assign FONT_ROW  = s2_valid ? frow : 4'd0;
    assign LB_WE     = s3_valid;
    assign LB_ADDR   = s3_valid ? s3_col : 7'd0;
    assign LB_DATA   = s3_valid ? FONT_DATA : 8'd0;
    assign DONE      = s3_valid && (s3_col == LAST_COL);

endmodule

// File: tb/tb_line_loader.sv
// tb/tb_line_loader.sv - self-checking bench for line_loader with text RAM and font ROM models.
module tb_line_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        LINE_START;
    logic [9:0]  ROW_NUM;
    logic [11:0] TXT_ADDR;
    logic [7:0]  TXT_DATA;
    logic [7:0]  FONT_CHAR;
    logic [3:0]  FONT_ROW;
    logic [7:0]  FONT_DATA;
    logic        LB_WE;
    logic [6:0]  LB_ADDR;
    logic [7:0]  LB_DATA;
    logic        BUSY;
    logic        DONE;
    logic        OVERRUN;

    int tests = 0;
    int fails = 0;

    logic [7:0] txt_mem  [4096];
    logic [7:0] font_mem [4096];

    line_loader dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LINE_START (LINE_START),
        .ROW_NUM    (ROW_NUM),
        .TXT_ADDR   (TXT_ADDR),
        .TXT_DATA   (TXT_DATA),
        .FONT_CHAR  (FONT_CHAR),
        .FONT_ROW   (FONT_ROW),
        .FONT_DATA  (FONT_DATA),
        .LB_WE      (LB_WE),
        .LB_ADDR    (LB_ADDR),
        .LB_DATA    (LB_DATA),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    // synchronous-read memories: data appears one cycle after the address
    always @(posedge CLK) begin
        TXT_DATA  <= txt_mem[TXT_ADDR];
        FONT_DATA <= font_mem[{FONT_CHAR, FONT_ROW}];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_txt_addr"},  32'(TXT_ADDR),  32'd0);
        check({tag, "_font_char"}, 32'(FONT_CHAR), 32'd0);
        check({tag, "_font_row"},  32'(FONT_ROW),  32'd0);
        check({tag, "_lb_we"},     32'(LB_WE),     32'd0);
        check({tag, "_lb_addr"},   32'(LB_ADDR),   32'd0);
        check({tag, "_lb_data"},   32'(LB_DATA),   32'd0);
        check({tag, "_busy"},      32'(BUSY),      32'd0);
        check({tag, "_done"},      32'(DONE),      32'd0);
        check({tag, "_overrun"},   32'(OVERRUN),   32'd0);
    endtask

    // Cycle k=0 presents the request; RUN occupies k=1..80, FLUSH k=81..82.
    task automatic run_load(input int row, input int ov1, input int ov2);
        int base;
        int frow;
        int wr;
        int bz;
        int dn;
        int ov;
        int ov_exp;
        logic busy_exp;
        base   = (row / 16) * 80;
        frow   = row % 16;
        wr     = 0;
        bz     = 0;
        dn     = 0;
        ov     = 0;
        ov_exp = 0;
        for (int k = 0; k <= 86; k++) begin
            @(negedge CLK);
            LINE_START = (k == 0) || (k == ov1) || (k == ov2);
            ROW_NUM    = (k == 0) ? 10'(row) : 10'($urandom_range(0, 1023));
            #1;
            busy_exp = (k >= 1) && (k <= 82);
            if (busy_exp && LINE_START) ov_exp++;
            check("busy",    32'(BUSY),    32'(busy_exp));
            check("overrun", 32'(OVERRUN), 32'(busy_exp && LINE_START));
            check("done",    32'(DONE),    32'(k == 82));
            check("lb_we",   32'(LB_WE),   32'((k >= 3) && (k <= 82)));
            if (k >= 1 && k <= 80)
                check("txt_addr", 32'(TXT_ADDR), 32'(base + k - 1));
            if (k >= 2 && k <= 81) begin
                check("font_char", 32'(FONT_CHAR), 32'(txt_mem[base + k - 2]));
                check("font_row",  32'(FONT_ROW),  32'(frow));
            end
            if (LB_WE && wr < 80) begin
                check("lb_addr", 32'(LB_ADDR), 32'(wr));
                check("lb_data", 32'(LB_DATA), 32'(font_mem[txt_mem[base + wr] * 16 + frow]));
                if (DONE) check("done_addr", 32'(LB_ADDR), 32'd79);
            end
            if (LB_WE) wr++;
            if (BUSY) bz++;
            if (DONE) dn++;
            if (OVERRUN) ov++;
        end
        LINE_START = 1'b0;
        check("write_count",   32'(wr), 32'd80);
        check("busy_cycles",   32'(bz), 32'd82);
        check("done_count",    32'(dn), 32'd1);
        check("overrun_count", 32'(ov), 32'(ov_exp));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            txt_mem[i]  = 8'($urandom);
            font_mem[i] = 8'($urandom);
        end
        RESET      = 1'b0;
        LINE_START = 1'b0;
        ROW_NUM    = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge CLK);
        RESET = 1'b1;

        // alternating 'H'/'E' on text row 0, font scan row 0
        for (int c = 0; c < 80; c++) txt_mem[c] = (c % 2 == 0) ? 8'h48 : 8'h45;
        run_load(0, -1, -1);

        // row 35: text row 2, scan row 3, plus two dropped requests (mid-load and last FLUSH cycle)
        run_load(35, 10, 82);

        for (int n = 0; n < 3; n++) run_load(int'($urandom_range(0, 479)), -1, -1);

        // vertical blank requests must be ignored completely
        begin
            int act;
            act = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge CLK);
                LINE_START = (k == 0) || (k == 4) || (k == 8);
                ROW_NUM    = (k == 0) ? 10'd480 : (k == 4) ? 10'd500 : 10'd1023;
                #1;
                if (BUSY || LB_WE || DONE || OVERRUN) act++;
            end
            LINE_START = 1'b0;
            check("vblank_activity", 32'(act), 32'd0);
        end

        // reset mid-RUN at col 40, then no writes until a fresh request
        begin
            int act;
            int row;
            act = 0;
            row = int'($urandom_range(0, 479));
            for (int k = 0; k <= 41; k++) begin
                @(negedge CLK);
                LINE_START = (k == 0);
                ROW_NUM    = 10'(row);
                #1;
            end
            LINE_START = 1'b0;
            check("pre_reset_txt_addr", 32'(TXT_ADDR), 32'((row / 16) * 80 + 40));
            RESET = 1'b0;
            #1;
            check_all_zero("midrun_reset");
            @(negedge CLK);
            RESET = 1'b1;
            for (int k = 0; k < 100; k++) begin
                @(negedge CLK);
                #1;
                if (LB_WE || BUSY || DONE) act++;
            end
            check("post_reset_activity", 32'(act), 32'd0);
        end

        // last visible scanline: text row 29 -> addresses 2320..2399
        run_load(479, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
